seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present on op/a/b/shamt.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 reserved.
REQ-008 a  input  WIDTH  operand A; also the shift source.
REQ-009 b  input  WIDTH  operand B; ignored for shifts.
REQ-010 shamt  input  SHW  shift amount; ignored for ops 0-3 and 7.
REQ-011 out_valid  output  1  result/flags are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  WIDTH  registered operation result.
REQ-014 carry  output  1  carry/no-borrow, or the last bit shifted out.
REQ-015 zero  output  1  result == 0.
REQ-016 msb  output  1  result[WIDTH-1].

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur on an edge where in_valid&in_ready; op/a/b/shamt SHALL be sampled only at acceptance, and in_valid SHALL be ignored outside IDLE.
REQ-019 Ops 0-3 and 7 SHALL register result/flags at the accept edge and go to DONE, giving out_valid the cycle after acceptance (latency 1).
REQ-020 ADD: result = (a+b) mod 2^WIDTH; carry = carry-out of bit WIDTH-1.
REQ-021 SUB: result = a + ~b + 1 (mod 2^WIDTH); carry = its carry-out (1 = no borrow, a >= b unsigned).
REQ-022 AND/XOR: bitwise; carry = 0. Op 7: result = 0, carry = 0.
REQ-023 Shift ops with shamt == 0 SHALL behave like REQ-019, with result = a and carry = 0.
REQ-024 Shift ops with shamt > 0 SHALL load a and a down-counter = shamt at acceptance, then enter SHIFT.
REQ-025 In SHIFT, each edge SHALL shift by one bit and decrement the counter; the edge that performs the last shift SHALL go to DONE, so out_valid rises exactly shamt+1 edges after acceptance.
REQ-026 Shift fill: SLL and SRL fill with 0; SRA replicates the original bit WIDTH-1; carry = the last bit shifted out.
REQ-027 zero and msb SHALL be derived from the final registered result and be valid whenever out_valid = 1.
REQ-028 In DONE, out_valid = 1 and result/carry/zero/msb SHALL hold stable until an edge with out_ready = 1, then the FSM SHALL return to IDLE (one request in flight, no overlap).
REQ-029 In SHIFT, out_valid SHALL be 0; result SHALL reflect the intermediate shift register and is not meaningful.

Reset
REQ-030 With rst_n = 0, asynchronously: state = IDLE, result = 0, carry = 0, counter = 0, out_valid = 0; zero = 1 and msb = 0 follow from result = 0, and in_ready = 1.
REQ-031 Reset asserted during SHIFT or DONE SHALL abort the operation; no stale result SHALL appear after release.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=32 unless stated)
REQ-033 ADD a=0xFFFFFFFF, b=1 -> out_valid next cycle; result 0, carry 1, zero 1, msb 0.
REQ-034 SUB a=5, b=7 -> result 0xFFFFFFFE, carry 0, zero 0, msb 1; SUB a=7, b=5 -> result 2, carry 1.
REQ-035 SLL a=0xC0000001, shamt=2 -> in_ready low 3 cycles, out_valid after 3 edges, result 0x00000004, carry 1; SRA a=0x80000010, shamt=4 -> result 0xF8000001, carry 0; shamt=0 -> result = a, latency 1.
REQ-036 Backpressure: hold out_ready = 0 for 3 cycles after out_valid while pulsing in_valid -> result unchanged, nothing accepted, IDLE one edge after out_ready = 1.
REQ-037 SRL shamt=31, rst_n pulsed low after 10 SHIFT cycles -> out_valid 0, result 0 immediately; a following ADD 3+4 returns 7 with latency 1.
REQ-038 WIDTH=8 build: ADD 0x80+0x80 -> result 0x00, carry 1, zero 1; SRA 0x90, shamt=7 -> result 0xFF, carry 0.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: a valid/ready request channel carrying
// op/operands and a valid/ready result channel carrying result and flags.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             msb;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, carry, zero, msb
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, carry, zero, msb
  );
endinterface

// File: rtl/seq_alu.sv
// Single-issue ALU: add/sub/and/xor complete in one cycle, shifts iterate one
// bit per clock. Result and flags are held in DONE until the consumer accepts.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpXor = 3'd3;
  localparam logic [2:0] OpSll = 3'd4;
  localparam logic [2:0] OpSrl = 3'd5;
  localparam logic [2:0] OpSra = 3'd6;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic             sub;
  logic             is_shift;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // SUB reuses the adder as a + ~b + 1 so carry-out doubles as no-borrow.
  always_comb begin
    sub      = (bus.op == OpSub);
    is_shift = (bus.op == OpSll) || (bus.op == OpSrl) || (bus.op == OpSra);
    b_eff    = sub ? ~bus.b : bus.b;
    sum      = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (is_shift && (bus.shamt != '0)) begin
            res_d   = bus.a;
            carry_d = 1'b0;
            cnt_d   = bus.shamt;
            state_d = StShift;
          end else begin
            state_d = StDone;
            unique case (bus.op)
              OpAdd, OpSub: {carry_d, res_d} = sum;
              OpAnd: begin
                res_d   = bus.a & bus.b;
                carry_d = 1'b0;
              end
              OpXor: begin
                res_d   = bus.a ^ bus.b;
                carry_d = 1'b0;
              end
              OpSll, OpSrl, OpSra: begin
                res_d   = bus.a;
                carry_d = 1'b0;
              end
              default: begin
                res_d   = '0;
                carry_d = 1'b0;
              end
            endcase
          end
        end
      end
      StShift: begin
        cnt_d = cnt_q - SHW'(1);
        // carry always captures the bit just shifted out
        unique case (op_q)
          OpSll:   {carry_d, res_d} = {res_q, 1'b0};
          OpSrl:   {res_d, carry_d} = {1'b0, res_q};
          default: {res_d, carry_d} = {res_q[WIDTH-1], res_q};
        endcase
        if (cnt_q == SHW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OpAdd;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = (res_q == '0);
  assign bus.msb       = res_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Randomised scoreboard bench for seq_alu (WIDTH=32) plus a short WIDTH=8 check.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  seq_alu_if #(.WIDTH(32), .SHW(5)) bus32 ();
  seq_alu_if #(.WIDTH(8),  .SHW(3)) bus8 ();

  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  seq_alu #(.WIDTH(8), .SHW(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        c;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on wide integers, shifts done in one step.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int sh);
    exp_t e;
    longint unsigned s;
    e.r = '0;
    e.c = 1'b0;
    case (op)
      3'd0: begin
        s   = longint'(a) + longint'(b);
        e.r = s[31:0];
        e.c = (s > 64'hFFFF_FFFF);
      end
      3'd1: begin
        e.r = a - b;
        e.c = (a >= b);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a ^ b;
      3'd4, 3'd5, 3'd6: begin
        if (sh == 0) begin
          e.r = a;
        end else if (op == 3'd4) begin
          e.r = a << sh;
          e.c = a[32-sh];
        end else if (op == 3'd5) begin
          e.r = a >> sh;
          e.c = a[sh-1];
        end else begin
          e.r = $signed(a) >>> sh;
          e.c = a[sh-1];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: compare every cycle the DUT presents a result, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && bus32.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output result=%0h expected=none", bus32.result);
      end else begin
        check("result", bus32.result, sb[0].r);
        check("carry", bus32.carry, sb[0].c);
        check("zero", bus32.zero, sb[0].r == 32'd0);
        check("msb", bus32.msb, sb[0].r[31]);
        if (bus32.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic scramble();
    bus32.in_valid = 1'($urandom_range(0, 1));
    bus32.op       = 3'($urandom_range(0, 7));
    bus32.a        = $urandom;
    bus32.b        = $urandom;
    bus32.shamt    = 5'($urandom_range(0, 31));
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input int hold);
    int lat;
    int exp_lat;
    exp_lat = (op inside {3'd4, 3'd5, 3'd6} && sh != 0) ? int'(sh) + 1 : 1;
    @(posedge clk); #1;
    bus32.op       = op;
    bus32.a        = a;
    bus32.b        = b;
    bus32.shamt    = sh;
    bus32.in_valid = 1'b1;
    bus32.out_ready = 1'b0;
    sb.push_back(model(op, a, b, int'(sh)));
    @(negedge clk);
    check("in_ready_idle", bus32.in_ready, 1);
    @(posedge clk); #1;
    scramble();
    lat = 1;
    @(negedge clk);
    while (!bus32.out_valid && lat < 64) begin
      check("in_ready_busy", bus32.in_ready, 0);
      @(posedge clk); #1;
      scramble();
      lat++;
      @(negedge clk);
    end
    check("latency", lat, exp_lat);
    check("in_ready_done", bus32.in_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      scramble();
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    scramble();
    @(negedge clk);
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b0;
    @(negedge clk);
    check("idle_after_release", {bus32.in_ready, bus32.out_valid}, 2'b10);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus32.in_valid = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus32.shamt = '0; bus32.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
    bus8.shamt = '0; bus8.out_ready = 1'b1;

    #2;
    check("rst_in_ready", bus32.in_ready, 1);
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_result", bus32.result, 0);
    check("rst_flags", {bus32.carry, bus32.zero, bus32.msb}, 3'b010);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    do_op(3'd1, 32'd5, 32'd7, 5'd0, 0);
    do_op(3'd1, 32'd7, 32'd5, 5'd0, 1);
    do_op(3'd4, 32'hC000_0001, 32'd0, 5'd2, 0);
    do_op(3'd6, 32'h8000_0010, 32'd0, 5'd4, 0);
    do_op(3'd5, 32'h1234_5678, 32'd0, 5'd0, 0);
    do_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    do_op(3'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd0, 3);
    do_op(3'd5, 32'h8000_0000, 32'd0, 5'd31, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 2));
    end

    // Abort a long shift with reset; nothing stale may surface afterwards.
    @(posedge clk); #1;
    bus32.op = 3'd5; bus32.a = $urandom; bus32.shamt = 5'd31; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("shift_busy", {bus32.in_ready, bus32.out_valid}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus32.out_valid, 0);
    check("abort_result", bus32.result, 0);
    check("abort_in_ready", bus32.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd4, 5'd0, 0);

    // WIDTH=8 build
    @(posedge clk); #1;
    bus8.op = 3'd0; bus8.a = 8'h80; bus8.b = 8'h80; bus8.shamt = 3'd0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_add_valid", bus8.out_valid, 1);
    check("w8_add_result", bus8.result, 8'h00);
    check("w8_add_flags", {bus8.carry, bus8.zero}, 2'b11);
    @(posedge clk); #1;
    bus8.op = 3'd6; bus8.a = 8'h90; bus8.shamt = 3'd7; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus8.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w8_sra_latency", lat, 8);
    check("w8_sra_result", bus8.result, 8'hFF);
    check("w8_sra_carry", bus8.carry, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
